// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and helpers for alu_share_arbiter.
//   - ALU function code macros (guarded so a system-wide definition takes precedence)
//   - state_t, req_id_t, CNT_W, is_mult()
`ifndef FADD
`define FADD   4'h0
`endif
`ifndef FSUB
`define FSUB   4'h1
`endif
`ifndef FSLL
`define FSLL   4'h2
`endif
`ifndef FMULT
`define FMULT  4'h3
`endif
`ifndef FMULTH
`define FMULTH 4'h4
`endif
`ifndef FSLT
`define FSLT   4'h5
`endif
`ifndef FSLTU
`define FSLTU  4'h6
`endif

package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef logic req_id_t;

  // Wide enough for MULT_LAT up to 15.
  localparam int CNT_W = 4;

  function automatic logic is_mult(input logic [3:0] func);
    return (func == `FMULT) || (func == `FMULTH);
  endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response/ALU bus of the shared-ALU arbiter.
//   master: cores + shared ALU side (drives requests and alu_result)
//   slave : the arbiter
// With ALU_ARB_STATS_EN defined the bus also carries grant_cnt0/1 and conflict_cnt.
interface alu_share_arbiter_if #(parameter int n = 32);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_func0, req_func1;
  logic [n-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]   rsp_valid;
  logic [n-1:0] rsp_result;
  logic [3:0]   alu_func;
  logic [n-1:0] alu_a, alu_b;
  logic [n-1:0] alu_result;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1, conflict_cnt;

  modport master (
    output req_valid, req_func0, req_func1, req_a0, req_a1, req_b0, req_b1, alu_result,
    input  req_ready, rsp_valid, rsp_result, alu_func, alu_a, alu_b,
    input  grant_cnt0, grant_cnt1, conflict_cnt
  );
  modport slave (
    input  req_valid, req_func0, req_func1, req_a0, req_a1, req_b0, req_b1, alu_result,
    output req_ready, rsp_valid, rsp_result, alu_func, alu_a, alu_b,
    output grant_cnt0, grant_cnt1, conflict_cnt
  );
`else
  modport master (
    output req_valid, req_func0, req_func1, req_a0, req_a1, req_b0, req_b1, alu_result,
    input  req_ready, rsp_valid, rsp_result, alu_func, alu_a, alu_b
  );
  modport slave (
    input  req_valid, req_func0, req_func1, req_a0, req_a1, req_b0, req_b1, alu_result,
    output req_ready, rsp_valid, rsp_result, alu_func, alu_a, alu_b
  );
`endif
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker.
//   req_i  : request bits, bit i = core i
//   ptr_i  : preferred core
//   adv_i  : move the pointer past the current winner
//   gnt_o  : one-hot grant (zero when no request)
//   ptr_o  : pointer for the next cycle
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    ptr_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output req_id_t    ptr_o
);
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ptr_i])       gnt_o[ptr_i]  = 1'b1;
    else if (req_i[~ptr_i]) gnt_o[~ptr_i] = 1'b1;
    // Winner is gnt_o[1] when a grant exists; the pointer then prefers the other core.
    ptr_o = adv_i ? req_id_t'(~gnt_o[1]) : ptr_i;
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two cores.
//   clock, nReset : rising-edge clock, async active-low reset
//   bus (slave)   : per-core valid/ready requests (func/a/b), one-cycle rsp_valid
//                   pulse with registered rsp_result, and the shared ALU func/a/b/result.
// Parameters: n (data width), MULT_LAT (EXEC cycles for FMULT/FMULTH, 1..15).
// Optional: define ALU_ARB_STATS_EN for saturating grant/conflict counters.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int n        = 32,
  parameter int MULT_LAT = 2
) (
  input  logic               clock,
  input  logic               nReset,
  alu_share_arbiter_if.slave bus
);
  localparam logic [CNT_W-1:0] MLAT = CNT_W'(MULT_LAT);

  state_t           state_q, state_d;
  req_id_t          gid_q, gid_d, ptr_q, ptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       func_q, func_d;
  logic [n-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       gnt, ready;
  logic             hs;
  req_id_t          gsel;
  logic [3:0]       sel_func;

  // The pointer is only consulted in IDLE, so advancing it at accept is
  // indistinguishable from advancing it on the response cycle.
  rr_arbiter2 u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .adv_i (hs),
    .gnt_o (gnt),
    .ptr_o (ptr_nxt)
  );

  // Gated by nReset so ready stays low while reset is held.
  assign ready         = (state_q == IDLE && nReset) ? gnt : 2'b00;
  assign hs            = |ready;
  assign gsel          = gnt[1];
  assign sel_func      = gsel ? bus.req_func1 : bus.req_func0;

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = (state_q == DONE) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = res_q;
  assign bus.alu_func   = func_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (hs) begin
        gid_d   = gsel;
        func_d  = sel_func;
        a_d     = gsel ? bus.req_a1 : bus.req_a0;
        b_d     = gsel ? bus.req_b1 : bus.req_b0;
        cnt_d   = is_mult(sel_func) ? MLAT : CNT_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          res_d   = bus.alu_result;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] g0_q, g1_q, cf_q;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      g0_q <= '0;
      g1_q <= '0;
      cf_q <= '0;
    end else if (hs) begin
      if (!gsel && g0_q != 16'hFFFF) g0_q <= g0_q + 16'd1;
      if (gsel && g1_q != 16'hFFFF)  g1_q <= g1_q + 16'd1;
      if (bus.req_valid == 2'b11 && cf_q != 16'hFFFF) cf_q <= cf_q + 16'd1;
    end
  end

  assign bus.grant_cnt0   = g0_q;
  assign bus.grant_cnt1   = g1_q;
  assign bus.conflict_cnt = cf_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: core drivers push nothing themselves;
// a negedge monitor predicts grants from the round-robin rule, queues the
// expected response and checks it when rsp_valid appears.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;
  localparam int N  = 32;
  localparam int ML = 2;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  alu_share_arbiter_if #(.n(N)) bus();

  alu_share_arbiter #(.n(N), .MULT_LAT(ML)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus)
  );

  // Core-side drive variables
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [3:0]   f0 = '0, f1 = '0;
  logic [N-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  assign bus.req_valid = {v1, v0};
  assign bus.req_func0 = f0;
  assign bus.req_func1 = f1;
  assign bus.req_a0    = a0;
  assign bus.req_a1    = a1;
  assign bus.req_b0    = b0;
  assign bus.req_b1    = b1;

  // Behavioural shared ALU
  function automatic logic [N-1:0] alu_ref(input logic [3:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    case (f)
      `FADD:   return a + b;
      `FSUB:   return a - b;
      `FSLL:   return a << b[4:0];
      `FMULT:  return p[N-1:0];
      `FMULTH: return p[2*N-1:N];
      `FSLT:   return {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      `FSLTU:  return {{(N-1){1'b0}}, (a < b)};
      default: return a ^ b;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_func, bus.alu_a, bus.alu_b);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int           id;
    logic [3:0]   f;
    logic [N-1:0] a, b, res;
    int           hs, due;
  } exp_t;
  exp_t         q[$];
  int           gl[$];
  int           last_gnt;
  int           m_g0, m_g1, m_conf;
  logic [N-1:0] last_res [2];

  exp_t mon_e;
  int   mon_g;
  bit   popped;

  always @(negedge clock) begin
    if (nReset) begin
      popped = 1'b0;
      if (bus.rsp_valid != 2'b00) begin
        if (q.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        else begin
          mon_e  = q.pop_front();
          popped = 1'b1;
          chk("rsp_core", 64'(bus.rsp_valid), (mon_e.id == 1) ? 64'd2 : 64'd1);
          chk("rsp_result", 64'(bus.rsp_result), 64'(mon_e.res));
          chk("rsp_cycle", 64'(cyc), 64'(mon_e.due));
          last_res[mon_e.id] = bus.rsp_result;
        end
      end
      chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
      if (q.size() != 0 || popped) chk("ready_busy", 64'(bus.req_ready), 64'd0);
      if (q.size() != 0 && cyc > q[0].hs && cyc < q[0].due) begin
        chk("alu_func", 64'(bus.alu_func), 64'(q[0].f));
        chk("alu_a", 64'(bus.alu_a), 64'(q[0].a));
        chk("alu_b", 64'(bus.alu_b), 64'(q[0].b));
      end
      if (q.size() == 0 && !popped && bus.req_valid != 2'b00) begin
        // Idle with requests pending: the preferred core is the one not served last.
        mon_g = (bus.req_valid == 2'b11) ? 1 - last_gnt : (bus.req_valid[1] ? 1 : 0);
        chk("grant", 64'(bus.req_ready), (mon_g == 1) ? 64'd2 : 64'd1);
        mon_e.id  = mon_g;
        mon_e.f   = mon_g ? f1 : f0;
        mon_e.a   = mon_g ? a1 : a0;
        mon_e.b   = mon_g ? b1 : b0;
        mon_e.res = alu_ref(mon_e.f, mon_e.a, mon_e.b);
        mon_e.hs  = cyc;
        mon_e.due = cyc + (is_mult(mon_e.f) ? 1 + ML : 2);
        q.push_back(mon_e);
        gl.push_back(mon_g);
        if (bus.req_valid == 2'b11) m_conf++;
        if (mon_g == 1) m_g1++; else m_g0++;
        last_gnt = mon_g;
      end
    end
  end

  task automatic set_req(input int c, input logic v, input logic [3:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    if (c == 0) begin v0 = v; f0 = f; a0 = a; b0 = b; end
    else        begin v1 = v; f1 = f; a1 = a; b1 = b; end
  endtask

  // Raise a request, hold it until accepted, then drop it just after the edge.
  task automatic do_op(input int c, input logic [3:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    int t;
    set_req(c, 1'b1, f, a, b);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.req_ready[c] && t < 300);
    if (t >= 300) chk("handshake_timeout", 64'(t), 64'd0);
    @(posedge clock);
    #1;
    set_req(c, 1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  function automatic logic [3:0] pick_func(input int k);
    case (k)
      0: return `FADD;
      1: return `FSUB;
      2: return `FSLL;
      3: return `FMULT;
      4: return `FMULTH;
      5: return `FSLT;
      6: return `FSLTU;
      default: return 4'hF;
    endcase
  endfunction

  task automatic rand_op(input int c);
    logic [N-1:0] a, b;
    a = $urandom;
    b = $urandom_range(0, 1) ? $urandom : N'($urandom_range(0, 40));
    do_op(c, pick_func($urandom_range(0, 7)), a, b);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Assert reset now, check every output is cleared, release just after the next edge.
  task automatic reset_pulse();
    nReset = 1'b0;
    q.delete();
    gl.delete();
    last_gnt = 1;
    m_g0 = 0; m_g1 = 0; m_conf = 0;
    last_res[0] = 32'hDEADBEEF;
    last_res[1] = 32'hDEADBEEF;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_alu_func", 64'(bus.alu_func), 64'd0);
    chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
    chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_stats", {16'd0, bus.grant_cnt0, bus.grant_cnt1, bus.conflict_cnt}, 64'd0);
`endif
    @(posedge clock);
    #2;
    nReset = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #2;
    reset_pulse();

    // Single core add
    do_op(0, `FADD, 118, 20);
    wait_drain();
    chk("add_118_20", 64'(last_res[0]), 64'd138);

    // Tie straight after reset: core0 first
    @(posedge clock); #2; reset_pulse();
    fork
      do_op(0, `FADD, 5, 3);
      do_op(1, `FSUB, 9, 4);
    join
    wait_drain();
    chk("tie_core0", 64'(last_res[0]), 64'd8);
    chk("tie_core1", 64'(last_res[1]), 64'd5);
    chk("tie_order", 64'(gl[0]), 64'd0);

    // Fairness under continuous contention
    @(posedge clock); #2; reset_pulse();
    fork
      begin for (int i = 0; i < 3; i++) rand_op(0); end
      begin for (int i = 0; i < 3; i++) rand_op(1); end
    join
    wait_drain();
    chk("fair_len", 64'(gl.size()), 64'd6);
    for (int i = 0; i < 6 && i < gl.size(); i++) chk("fair_order", 64'(gl[i]), 64'(i % 2));
`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0", 64'(bus.grant_cnt0), 64'd3);
    chk("stat_grant1", 64'(bus.grant_cnt1), 64'd3);
    chk("stat_conflict", 64'(bus.conflict_cnt), 64'd5);
`endif

    // Multiplies on core1
    do_op(1, `FMULT, 25, 32'hFFFFFFFE);
    wait_drain();
    chk("mult_lo", 64'(last_res[1]), 64'hFFFFFFCE);
    do_op(1, `FMULTH, 25, 32'hFFFFFFFE);
    wait_drain();
    chk("mult_hi", 64'(last_res[1]), 64'hFFFFFFFF);

    // Randomised traffic with gaps
    fork
      begin for (int i = 0; i < 15; i++) begin repeat ($urandom_range(0, 3)) @(posedge clock); #1; rand_op(0); end end
      begin for (int i = 0; i < 15; i++) begin repeat ($urandom_range(0, 3)) @(posedge clock); #1; rand_op(1); end end
    join
    wait_drain();
`ifdef ALU_ARB_STATS_EN
    chk("stat_grant0_rand", 64'(bus.grant_cnt0), 64'(m_g0));
    chk("stat_grant1_rand", 64'(bus.grant_cnt1), 64'(m_g1));
    chk("stat_conflict_rand", 64'(bus.conflict_cnt), 64'(m_conf));
`endif

    // Reset during the EXEC of a multiply: op dropped, no response
    do_op(0, `FMULT, 7, 9);
    #1;
    reset_pulse();
    repeat (6) @(posedge clock);
    #1;
    chk("dropped_no_rsp", 64'(last_res[0]), 64'hDEADBEEF);
    do_op(0, `FSLT, 32'hFFFFFFFE, 5);
    wait_drain();
    chk("slt_after_reset", 64'(last_res[0]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end
endmodule
